ascon_serial_sequencer: RTL and testbench

- Host-side controller for the bit-serial Ascon core.
- Accepts one parallel request: key, nonce, associated data, data block and mode.
- Shifts the request into the core's serial inputs, issues the start strobe and waits for the core's ready.
- Deserializes the core's serial output-data and tag streams into a parallel response with a valid/ready handshake; a watchdog bounds the wait.

---
 rtl/ascon_serial_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ascon_serial_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_serial_sequencer.sv
// ascon_serial_sequencer: shifts one parallel Ascon request into the bit-serial core and collects its result.
// Latency: accept -> rsp_valid = W load + 1 start + n wait + W unload + 1 cycles; wait bounded by TIMEOUT.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until rsp_valid && rsp_ready.
module ascon_serial_sequencer #(
   parameter int W       = 128,
   parameter int TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_decrypt,
   input  logic [W-1:0] req_key,
   input  logic [W-1:0] req_nonce,
   input  logic [W-1:0] req_ad,
   input  logic [W-1:0] req_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic [W-1:0] rsp_tag,
   output logic         rsp_timeout,
   output logic         core_key_si,
   output logic         core_nonce_si,
   output logic         core_ad_si,
   output logic         core_data_si,
   output logic         core_start,
   output logic         core_decrypt,
   input  logic         core_out_so,
   input  logic         core_tag_so,
   input  logic         core_ready_so
);

   localparam int BW = $clog2(W + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
   localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_UNLOAD,
      S_RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    key_sr;
   logic [W-1:0]    nonce_sr;
   logic [W-1:0]    ad_sr;
   logic [W-1:0]    data_sr;
   logic            mode;
   logic            armed;
   logic [BW-1:0]   bit_cnt;
   logic [TW-1:0]   wdog;
   logic            bit_last;
   logic            wd_expire;
   logic            ready_hit;

   // A ready that was already high when the wait began is stale; only a
   // ready seen after a low sample (armed) marks a finished operation.
   assign bit_last  = (bit_cnt == BIT_LAST);
   assign wd_expire = (wdog >= WD_LAST);
   assign ready_hit = armed && core_ready_so;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and Moore outputs towards host and core
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      core_key_si   = 1'b0;
      core_nonce_si = 1'b0;
      core_ad_si    = 1'b0;
      core_data_si  = 1'b0;
      core_start    = 1'b0;
      core_decrypt  = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            core_key_si   = key_sr[W-1];
            core_nonce_si = nonce_sr[W-1];
            core_ad_si    = ad_sr[W-1];
            core_data_si  = data_sr[W-1];
            core_decrypt  = mode;
            if (bit_last) state_nxt = S_START;
         end
         S_START: begin
            core_start   = 1'b1;
            core_decrypt = mode;
            state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            core_decrypt = mode;
            if (ready_hit)      state_nxt = S_UNLOAD;
            else if (wd_expire) state_nxt = S_RESP;
         end
         S_UNLOAD: begin
            core_decrypt = mode;
            if (bit_last) state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: request shift registers, counters and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_sr      <= '0;
         nonce_sr    <= '0;
         ad_sr       <= '0;
         data_sr     <= '0;
         mode        <= 1'b0;
         armed       <= 1'b0;
         bit_cnt     <= '0;
         wdog        <= '0;
         rsp_data    <= '0;
         rsp_tag     <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  key_sr   <= req_key;
                  nonce_sr <= req_nonce;
                  ad_sr    <= req_ad;
                  data_sr  <= req_data;
                  mode     <= req_decrypt;
                  bit_cnt  <= '0;
               end
            end
            S_LOAD: begin
               key_sr   <= {key_sr[W-2:0], 1'b0};
               nonce_sr <= {nonce_sr[W-2:0], 1'b0};
               ad_sr    <= {ad_sr[W-2:0], 1'b0};
               data_sr  <= {data_sr[W-2:0], 1'b0};
               if (!bit_last) bit_cnt <= bit_cnt + BW'(1);
            end
            S_START: begin
               wdog  <= '0;
               armed <= 1'b0;
            end
            S_WAIT: begin
               if (!core_ready_so) armed <= 1'b1;
               if (wdog != WD_MAX) wdog <= wdog + TW'(1);
               if (ready_hit) begin
                  bit_cnt <= '0;
               end else if (wd_expire) begin
                  rsp_data    <= '0;
                  rsp_tag     <= '0;
                  rsp_timeout <= 1'b1;
               end
            end
            S_UNLOAD: begin
               // Shifting in at the LSB leaves the first sampled bit at W-1.
               rsp_data <= {rsp_data[W-2:0], core_out_so};
               rsp_tag  <= {rsp_tag[W-2:0], core_tag_so};
               if (!bit_last) bit_cnt <= bit_cnt + BW'(1);
               if (bit_last) rsp_timeout <= 1'b0;
            end
            S_RESP: begin
               if (rsp_ready) rsp_timeout <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_serial_sequencer.sv
// tb_ascon_serial_sequencer: drives requests through the sequencer against a behavioural serial-core model.
// Latency: checks accept-to-response cycle counts, serial ordering, start strobe and watchdog abort.
// Backpressure: stalls the response handshake with a second request pending and checks stability.
module tb_ascon_serial_sequencer;

   localparam int W       = 128;
   localparam int TIMEOUT = 4096;
   localparam int MAXC    = 2 * W + TIMEOUT + 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic         req_decrypt;
   logic [W-1:0] req_key;
   logic [W-1:0] req_nonce;
   logic [W-1:0] req_ad;
   logic [W-1:0] req_data;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic [W-1:0] rsp_tag;
   logic         rsp_timeout;
   logic         core_key_si;
   logic         core_nonce_si;
   logic         core_ad_si;
   logic         core_data_si;
   logic         core_start;
   logic         core_decrypt;
   logic         core_out_so;
   logic         core_tag_so;
   logic         core_ready_so;

   int n_chk  = 0;
   int n_fail = 0;

   // Core model knobs: WAIT cycle at which ready rises (0 = never), ready level while idle
   int   rdy_n    = 10;
   logic idle_rdy = 1'b0;

   logic [W-1:0] cap_k, cap_n, cap_a, cap_d;
   logic [W-1:0] got_k, got_n, got_a, got_d;
   logic [W-1:0] m_out, m_tag;

   ascon_serial_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_decrypt   (req_decrypt),
      .req_key       (req_key),
      .req_nonce     (req_nonce),
      .req_ad        (req_ad),
      .req_data      (req_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_tag       (rsp_tag),
      .rsp_timeout   (rsp_timeout),
      .core_key_si   (core_key_si),
      .core_nonce_si (core_nonce_si),
      .core_ad_si    (core_ad_si),
      .core_data_si  (core_data_si),
      .core_start    (core_start),
      .core_decrypt  (core_decrypt),
      .core_out_so   (core_out_so),
      .core_tag_so   (core_tag_so),
      .core_ready_so (core_ready_so)
   );

   always #5 clk = ~clk;

   // Stand-in for the Ascon permutation: any fixed function of the inputs will do
   function automatic logic [W-1:0] ref_out(input logic [W-1:0] k, input logic [W-1:0] n,
                                            input logic [W-1:0] a, input logic [W-1:0] d,
                                            input logic dec);
      return d ^ k ^ {n[W/2-1:0], n[W-1:W/2]} ^ a ^ {W{dec}};
   endfunction

   function automatic logic [W-1:0] ref_tag(input logic [W-1:0] k, input logic [W-1:0] n,
                                            input logic [W-1:0] a, input logic [W-1:0] d,
                                            input logic dec);
      return (k ^ a) + n + d + W'(dec);
   endfunction

   function automatic logic [W-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Serial core model: keeps the last W bits seen on each line, answers a
   // start strobe by raising ready after rdy_n WAIT cycles, then streams
   // its result words MSB first.
   initial begin : core_model
      int phase;
      int wc;
      int bi;
      phase = 0;
      wc = 0;
      bi = 0;
      core_ready_so = 1'b0;
      core_out_so = 1'b0;
      core_tag_so = 1'b0;
      cap_k = '0; cap_n = '0; cap_a = '0; cap_d = '0;
      forever begin
         @(negedge clk);
         if (rst_n && !core_start) begin
            cap_k = {cap_k[W-2:0], core_key_si};
            cap_n = {cap_n[W-2:0], core_nonce_si};
            cap_a = {cap_a[W-2:0], core_ad_si};
            cap_d = {cap_d[W-2:0], core_data_si};
         end
         if (!rst_n) begin
            phase = 0;
            core_ready_so = 1'b0;
            core_out_so = 1'b0;
            core_tag_so = 1'b0;
         end else if (core_start) begin
            got_k = cap_k; got_n = cap_n; got_a = cap_a; got_d = cap_d;
            m_out = ref_out(cap_k, cap_n, cap_a, cap_d, core_decrypt);
            m_tag = ref_tag(cap_k, cap_n, cap_a, cap_d, core_decrypt);
            phase = 1;
            wc = 0;
         end else if (phase == 1) begin
            wc++;
            core_ready_so = (rdy_n != 0 && wc == rdy_n);
            if (core_ready_so) begin
               phase = 2;
               bi = 0;
            end
         end else if (phase == 2) begin
            core_out_so = m_out[W-1-bi];
            core_tag_so = m_tag[W-1-bi];
            bi++;
            if (bi == W) phase = 0;
         end else begin
            core_ready_so = idle_rdy;
            core_out_so = 1'b0;
            core_tag_so = 1'b0;
         end
      end
   end

   // One full operation from the IDLE negedge up to the first RESP cycle
   task automatic do_op(input string tg, input logic [W-1:0] k, input logic [W-1:0] n,
                        input logic [W-1:0] a, input logic [W-1:0] d, input logic dec,
                        input int rn, input logic irdy, input logic hold);
      int lat, s_cnt, s_at, dec_bad, rdy_bad, elat;
      logic [W-1:0] eo, et;
      rdy_n = rn;
      idle_rdy = irdy;
      req_key = k; req_nonce = n; req_ad = a; req_data = d; req_decrypt = dec;
      req_valid = 1'b1;
      lat = -1; s_cnt = 0; s_at = -1; dec_bad = 0; rdy_bad = 0;
      for (int c = 1; c <= MAXC; c++) begin
         @(negedge clk);
         if (c == 1 || hold) begin
            req_key = rnd(); req_nonce = rnd(); req_ad = rnd(); req_data = rnd();
            req_decrypt = ~dec;
            req_valid = hold;
         end
         if (core_start) begin
            s_cnt++;
            s_at = c;
         end
         if (rsp_valid) begin
            lat = c;
            break;
         end
         if (core_decrypt !== dec) dec_bad++;
         if (req_ready !== 1'b0) rdy_bad++;
      end
      req_valid = 1'b0;
      if (rn > 0) begin
         eo = ref_out(k, n, a, d, dec);
         et = ref_tag(k, n, a, d, dec);
         elat = 2 * W + 2 + rn;
      end else begin
         eo = '0;
         et = '0;
         elat = W + 2 + TIMEOUT;
      end
      check({tg, "_latency"}, W'(lat), W'(elat));
      check({tg, "_start_count"}, W'(s_cnt), W'(1));
      check({tg, "_start_cycle"}, W'(s_at), W'(W + 1));
      check({tg, "_decrypt_line"}, W'(dec_bad), W'(0));
      check({tg, "_req_ready_busy"}, W'(rdy_bad), W'(0));
      check({tg, "_ser_key"}, got_k, k);
      check({tg, "_ser_nonce"}, got_n, n);
      check({tg, "_ser_ad"}, got_a, a);
      check({tg, "_ser_data"}, got_d, d);
      check({tg, "_rsp_data"}, rsp_data, eo);
      check({tg, "_rsp_tag"}, rsp_tag, et);
      check({tg, "_rsp_timeout"}, W'(rsp_timeout), W'(rn == 0));
   endtask

   // Hold off the response for 'stall' cycles (optionally with a pending request), then handshake
   task automatic consume(input string tg, input int stall, input logic pend,
                          input logic [W-1:0] k, input logic [W-1:0] n,
                          input logic [W-1:0] a, input logic [W-1:0] d, input logic dec);
      logic [W-1:0] d0, t0;
      logic to0;
      int bad;
      d0 = rsp_data; t0 = rsp_tag; to0 = rsp_timeout; bad = 0;
      if (pend) begin
         req_key = k; req_nonce = n; req_ad = a; req_data = d; req_decrypt = dec;
         req_valid = 1'b1;
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_tag !== t0 ||
             rsp_timeout !== to0 || req_ready !== 1'b0) bad++;
      end
      if (stall > 0) check({tg, "_stall_stable"}, W'(bad), W'(0));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tg, "_hs_rsp_valid"}, W'(rsp_valid), W'(0));
      check({tg, "_hs_req_ready"}, W'(req_ready), W'(1));
      check({tg, "_idle_decrypt"}, W'(core_decrypt), W'(0));
   endtask

   task automatic check_reset_outputs(input string tg);
      check({tg, "_req_ready"}, W'(req_ready), W'(1));
      check({tg, "_rsp_valid"}, W'(rsp_valid), W'(0));
      check({tg, "_rsp_timeout"}, W'(rsp_timeout), W'(0));
      check({tg, "_rsp_data"}, rsp_data, '0);
      check({tg, "_rsp_tag"}, rsp_tag, '0);
      check({tg, "_core_lines"}, W'({core_key_si, core_nonce_si, core_ad_si, core_data_si,
                                     core_start, core_decrypt}), W'(0));
   endtask

   // Global time bound
   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   // Directed sequence of scenarios
   initial begin
      logic [W-1:0] k, n, a, d;
      logic dec;
      rst_n = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      req_decrypt = 1'b0;
      req_key = '0; req_nonce = '0; req_ad = '0; req_data = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_req_ready", W'(req_ready), W'(1));

      // Encrypt path with fixed vectors, ready 10 WAIT cycles after start
      do_op("enc", 128'h000102030405060708090A0B0C0D0E0F, 128'h101112131415161718191A1B1C1D1E1F,
            '0, 128'h202122232425262728292A2B2C2D2E2F, 1'b0, 10, 1'b0, 1'b0);
      consume("enc", 0, 1'b0, '0, '0, '0, '0, 1'b0);

      // Decrypt mode
      do_op("dec", rnd(), rnd(), rnd(), rnd(), 1'b1, 10, 1'b0, 1'b0);
      consume("dec", 0, 1'b0, '0, '0, '0, '0, 1'b0);

      // Stale ready: high through LOAD/START, low in WAIT, rises at WAIT cycle 6
      do_op("stale", rnd(), rnd(), rnd(), rnd(), 1'b0, 6, 1'b1, 1'b0);
      consume("stale", 0, 1'b0, '0, '0, '0, '0, 1'b0);

      // Randomized operations: early rsp_ready, req_valid held while busy
      for (int i = 0; i < 4; i++) begin
         rsp_ready = (i == 0);
         do_op($sformatf("rnd%0d", i), rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)),
               int'($urandom_range(2, 40)), 1'($urandom_range(0, 1)), (i == 1));
         consume($sformatf("rnd%0d", i), 0, 1'b0, '0, '0, '0, '0, 1'b0);
      end

      // Backpressure: 20-cycle stall with the next request already presented
      do_op("bp", rnd(), rnd(), rnd(), rnd(), 1'b1, int'($urandom_range(2, 20)), 1'b0, 1'b0);
      k = rnd(); n = rnd(); a = rnd(); d = rnd(); dec = 1'($urandom_range(0, 1));
      consume("bp", 20, 1'b1, k, n, a, d, dec);
      do_op("bp_next", k, n, a, d, dec, 10, 1'b0, 1'b0);
      consume("bp_next", 0, 1'b0, '0, '0, '0, '0, 1'b0);

      // Watchdog: ready never rises
      do_op("tmo", rnd(), rnd(), rnd(), rnd(), 1'b0, 0, 1'b0, 1'b0);
      consume("tmo", 0, 1'b0, '0, '0, '0, '0, 1'b0);

      // Reset while unloading bit 50
      rdy_n = 10;
      idle_rdy = 1'b0;
      req_key = rnd(); req_nonce = rnd(); req_ad = rnd(); req_data = rnd();
      req_decrypt = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (W + 1 + 10 + 50) @(negedge clk);
      check("mid_unload_busy", W'({req_ready, core_decrypt}), W'(2'b01));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_release_req_ready", W'(req_ready), W'(1));
      do_op("after_reset", rnd(), rnd(), rnd(), rnd(), 1'b0, 12, 1'b0, 1'b0);
      consume("after_reset", 3, 1'b0, '0, '0, '0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
